// File: rtl/stack_sequencer.sv
// Command sequencer for a WebAssembly-style operand stack: validates commands against a
// shadow depth count, drives the stack op/data pins in order and reports completion.
module stack_sequencer #(
  parameter int WIDTH    = 8,
  parameter int CAPACITY = 128,
  parameter int DW       = $clog2(CAPACITY + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic             done,
  output logic             error,
  output logic [2:0]       err_code,
  output logic [DW-1:0]    depth,
  output logic [1:0]       stack_op,
  output logic [WIDTH-1:0] stack_data,
  input  logic [WIDTH-1:0] stack_tos,
  input  logic [1:0]       stack_status
);

  localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_POP, S_REPL, S_PUSH, S_CHK, S_FAULT
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,  OP_CONST = 4'd1,  OP_DROP = 4'd2,  OP_ADD  = 4'd3,
    OP_SUB  = 4'd4,  OP_AND   = 4'd5,  OP_OR   = 4'd6,  OP_XOR  = 4'd7,
    OP_EQ   = 4'd8,  OP_LTU   = 4'd9,  OP_SHL  = 4'd10, OP_SHRU = 4'd11
  } op_t;

  typedef enum logic [1:0] {
    SOP_NONE, SOP_PUSH, SOP_POP, SOP_REPLACE
  } sop_t;

  typedef enum logic [1:0] {
    ST_NONE, ST_EMPTY, ST_UNDERFLOW, ST_OVERFLOW
  } sstat_t;

  typedef enum logic [2:0] {
    E_NONE, E_UNDERFLOW, E_OVERFLOW, E_ILLEGAL, E_FAULT
  } err_t;

  state_t           state, state_nxt;
  op_t              op_q;
  logic [WIDTH-1:0] imm_q;
  logic [WIDTH-1:0] b_q;
  logic             accept;
  logic             is_illegal;
  logic             is_bin;
  err_t             pre_code;
  logic             fin;
  err_t             fin_code;

  function automatic logic [WIDTH-1:0] alu(input op_t op, input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_EQ:   r = WIDTH'(a == b);
      OP_LTU:  r = WIDTH'(a < b);
      OP_SHL:  r = a << b[SW-1:0];
      OP_SHRU: r = a >> b[SW-1:0];
      default: r = '0;
    endcase
    return r;
  endfunction

  assign accept     = cmd_valid && (state == S_IDLE);
  assign is_illegal = cmd_op > 4'd11;
  assign is_bin     = (cmd_op >= 4'd3) && !is_illegal;

  // Pre-check against the shadow depth so a bad command never reaches the stack.
  always_comb begin
    pre_code = E_NONE;
    if (is_illegal)
      pre_code = E_ILLEGAL;
    else if ((is_bin && depth < DW'(2)) || (cmd_op == OP_DROP && depth == '0))
      pre_code = E_UNDERFLOW;
    else if (cmd_op == OP_CONST && depth == DW'(CAPACITY))
      pre_code = E_OVERFLOW;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and completion decode
  always_comb begin
    state_nxt = state;
    fin       = 1'b0;
    fin_code  = E_NONE;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (pre_code != E_NONE) begin
            fin      = 1'b1;
            fin_code = pre_code;
          end else if (cmd_op == OP_NOP) begin
            fin = 1'b1;
          end else if (cmd_op == OP_CONST) begin
            state_nxt = S_PUSH;
          end else begin
            state_nxt = S_POP;
          end
        end
      end
      S_POP:  state_nxt = (op_q == OP_DROP) ? S_CHK : S_REPL;
      S_REPL: state_nxt = (stack_status == ST_UNDERFLOW) ? S_FAULT : S_CHK;
      S_PUSH: state_nxt = S_CHK;
      S_CHK: begin
        state_nxt = S_IDLE;
        fin       = 1'b1;
        if (stack_status == ST_UNDERFLOW || stack_status == ST_OVERFLOW)
          fin_code = E_FAULT;
      end
      S_FAULT: begin
        state_nxt = S_IDLE;
        fin       = 1'b1;
        fin_code  = E_FAULT;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs; REPL data is the one combinational path from stack_tos (now operand a).
  always_comb begin
    cmd_ready  = (state == S_IDLE);
    stack_op   = SOP_NONE;
    stack_data = '0;
    case (state)
      S_POP:  stack_op = SOP_POP;
      S_REPL: begin
        stack_op   = SOP_REPLACE;
        stack_data = alu(op_q, stack_tos, b_q);
      end
      S_PUSH: begin
        stack_op   = SOP_PUSH;
        stack_data = imm_q;
      end
      default: ;
    endcase
  end

  // Command latches, shadow depth and registered completion status
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q     <= OP_NOP;
      imm_q    <= '0;
      b_q      <= '0;
      depth    <= '0;
      done     <= 1'b0;
      error    <= 1'b0;
      err_code <= '0;
    end else begin
      done     <= fin;
      error    <= fin && (fin_code != E_NONE);
      err_code <= fin_code;
      if (accept) begin
        op_q  <= op_t'(cmd_op);
        imm_q <= cmd_imm;
        if (pre_code == E_NONE) begin
          if (cmd_op == OP_CONST)
            depth <= depth + DW'(1);
          else if (cmd_op != OP_NOP)
            depth <= depth - DW'(1);
        end
      end
      if (state == S_POP)
        b_q <= stack_tos;
    end
  end

endmodule

// File: tb/tb_stack_sequencer.sv
// Bench for stack_sequencer: attaches a behavioural operand stack and checks every command
// against a queue-based reference of the stack contents, error codes and latency.
module tb_stack_sequencer;

  localparam int W   = 8;
  localparam int CAP = 128;
  localparam int DW  = $clog2(CAP + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [3:0]    cmd_op = '0;
  logic [W-1:0]  cmd_imm = '0;
  logic          done;
  logic          error;
  logic [2:0]    err_code;
  logic [DW-1:0] depth;
  logic [1:0]    stack_op;
  logic [W-1:0]  stack_data;
  logic [W-1:0]  stack_tos;
  logic [1:0]    stack_status;

  int checks = 0;
  int errors = 0;

  stack_sequencer #(.WIDTH(W), .CAPACITY(CAP)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_imm(cmd_imm),
    .done(done), .error(error), .err_code(err_code), .depth(depth),
    .stack_op(stack_op), .stack_data(stack_data),
    .stack_tos(stack_tos), .stack_status(stack_status)
  );

  always #5 clk = ~clk;

  // Attached stack: tos/status reflect the op applied on the previous edge
  logic [W-1:0] smem [CAP];
  int           sp;
  logic [1:0]   sstat;
  bit           force_ovf = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sp    <= 0;
      sstat <= 2'd1;
    end else begin
      case (stack_op)
        2'd1: if (sp == CAP || force_ovf) sstat <= 2'd3;
              else begin smem[sp] <= stack_data; sp <= sp + 1; sstat <= 2'd0; end
        2'd2: if (sp == 0) sstat <= 2'd2;
              else begin sp <= sp - 1; sstat <= (sp == 1) ? 2'd1 : 2'd0; end
        2'd3: if (sp == 0) sstat <= 2'd2;
              else begin smem[sp-1] <= stack_data; sstat <= 2'd0; end
        default: sstat <= (sp == 0) ? 2'd1 : 2'd0;
      endcase
    end
  end

  assign stack_tos    = (sp > 0) ? smem[sp-1] : 8'h00;
  assign stack_status = sstat;

  // Reference: stack contents as a queue, back = top
  logic [W-1:0] rq[$];
  bit           tos_ok = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_alu(input int op, input int a, input int b);
    int r;
    case (op)
      3:  r = (a + b) % 256;
      4:  r = (a - b + 256) % 256;
      5:  r = a & b;
      6:  r = a | b;
      7:  r = a ^ b;
      8:  r = (a == b) ? 1 : 0;
      9:  r = (a < b) ? 1 : 0;
      10: r = (a * (1 << (b % 8))) % 256;
      default: r = a / (1 << (b % 8));
    endcase
    return W'(r);
  endfunction

  // Issue one command and check its outcome; fault=1 means the stack is rigged to fail the push
  task automatic do_cmd(input logic [3:0] op, input logic [W-1:0] imm, input int gap, input bit fault);
    int exp_code, exp_lat, exp_seq, d, seq, n;
    logic [W-1:0] a, b;
    bit got;
    d = rq.size();
    exp_code = 0; exp_lat = 1; exp_seq = 0;
    if (op >= 12) exp_code = 3;
    else if (op == 0) exp_code = 0;
    else if (op == 1) begin
      if (d == CAP) exp_code = 2;
      else begin rq.push_back(imm); exp_lat = 3; exp_seq = 1; if (fault) exp_code = 4; end
    end else if (op == 2) begin
      if (d == 0) exp_code = 1;
      else begin void'(rq.pop_back()); exp_lat = 3; exp_seq = 2; end
    end else begin
      if (d < 2) exp_code = 1;
      else begin
        b = rq.pop_back();
        a = rq.pop_back();
        rq.push_back(ref_alu(op, a, b));
        exp_lat = 4; exp_seq = 11;
      end
    end
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      if (i == 0) check("done_pulse_width", done, 1'b0);
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_imm = imm;
    check("cmd_ready", cmd_ready, 1'b1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_op = 4'($urandom); cmd_imm = W'($urandom);
    seq = 0; n = 0; got = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (done) begin n = i; got = 1'b1; break; end
      if (stack_op != 2'd0) seq = seq * 4 + int'(stack_op);
    end
    if (!got) begin
      check("done_timeout", done, 1'b1);
      return;
    end
    check("latency", n, exp_lat);
    check("error", error, exp_code != 0);
    check("err_code", err_code, exp_code);
    check("depth", depth, rq.size());
    check("stack_op_seq", seq, exp_seq);
    if (fault) tos_ok = 1'b0;
    if (tos_ok) check("tos", stack_tos, (rq.size() > 0) ? rq[$] : 8'h00);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rq.delete();
    tos_ok = 1'b1;
  endtask

  initial begin
    int r;
    // Reset values
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_stack_op", stack_op, 2'd0);
    check("rst_stack_data", stack_data, 8'h00);
    check("rst_depth", depth, 0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_err_code", err_code, 3'd0);
    @(negedge clk);
    reset = 1'b0;

    // CONST 5, CONST 3, ADD
    do_cmd(4'd1, 8'd5, 0, 1'b0);
    do_cmd(4'd1, 8'd3, 0, 1'b0);
    do_cmd(4'd3, 8'd0, 0, 1'b0);
    check("add_tos", stack_tos, 8'd8);
    check("add_depth", depth, 1);
    // Binary op with depth 1 underflows
    do_cmd(4'd3, 8'd0, 1, 1'b0);
    // Wrapping SUB, EQ, SHL
    do_cmd(4'd1, 8'h10, 0, 1'b0);
    do_cmd(4'd1, 8'h30, 0, 1'b0);
    do_cmd(4'd4, 8'h00, 0, 1'b0);
    check("sub_wrap_tos", stack_tos, 8'hE0);
    do_cmd(4'd1, 8'hE0, 0, 1'b0);
    do_cmd(4'd8, 8'h00, 0, 1'b0);
    check("eq_tos", stack_tos, 8'h01);
    do_cmd(4'd1, 8'h03, 0, 1'b0);
    do_cmd(4'd10, 8'h00, 0, 1'b0);
    check("shl_tos", stack_tos, 8'h08);

    // Fill to capacity, then overflow
    apply_reset();
    for (int i = 0; i < CAP; i++) do_cmd(4'd1, W'($urandom), 0, 1'b0);
    check("full_depth", depth, CAP);
    do_cmd(4'd1, 8'hAA, 0, 1'b0);

    // Stack reports overflow during CHK of a CONST; then an illegal op
    do_cmd(4'd2, 8'h00, 0, 1'b0);
    force_ovf = 1'b1;
    do_cmd(4'd1, 8'h55, 0, 1'b1);
    force_ovf = 1'b0;
    check("fault_ready", cmd_ready, 1'b1);
    do_cmd(4'd13, 8'h00, 1, 1'b0);

    // Reset during REPL of an ADD
    apply_reset();
    do_cmd(4'd1, 8'd1, 0, 1'b0);
    do_cmd(4'd1, 8'd2, 0, 1'b0);
    cmd_valid = 1'b1; cmd_op = 4'd3;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("repl_stack_op", stack_op, 2'd3);
    reset = 1'b1;
    #1;
    check("abort_stack_op", stack_op, 2'd0);
    @(negedge clk);
    reset = 1'b0;
    check("abort_depth", depth, 0);
    check("abort_done", done, 1'b0);
    check("abort_ready", cmd_ready, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("abort_no_done", done, 1'b0);
    end
    rq.delete();
    tos_ok = 1'b1;

    // Randomized command stream
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 38)      do_cmd(4'd1, W'($urandom), $urandom_range(0, 2), 1'b0);
      else if (r < 50) do_cmd(4'd2, W'($urandom), $urandom_range(0, 2), 1'b0);
      else if (r < 90) do_cmd(4'($urandom_range(3, 11)), W'($urandom), $urandom_range(0, 2), 1'b0);
      else if (r < 95) do_cmd(4'd0, W'($urandom), $urandom_range(0, 2), 1'b0);
      else             do_cmd(4'($urandom_range(12, 15)), W'($urandom), $urandom_range(0, 2), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
